branch_target_buffer_sa: RTL and testbench

Parametrised set-associative branch target buffer for the fetch stage of the RISC-V pipeline.
- Lookup is combinational on the fetch PC and returns hit, predicted target and a taken prediction from a per-entry 2-bit saturating counter.
- Updates come from the execute stage and are written on the clock edge, gated by stall.
- Compared with the previous direct-mapped, tag-only BTB it adds valid bits, N-way associativity with LRU replacement, direction prediction, flush and reset.

---
 rtl/branch_target_buffer_sa.sv | 239 +++++++++++++++++++++++
 tb/tb_branch_target_buffer_sa.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer_sa.sv
// ---------------------------------------------------------------------------
// branch_target_buffer_sa
//
// Set-associative branch target buffer for the fetch stage. The lookup is
// purely combinational on the fetch PC. The execute stage writes updates on
// the rising clock edge.
//
// Each entry holds:
//   - a valid bit
//   - a tag
//   - a target address
//   - a 2-bit saturating direction counter
//
// Each set also holds replacement state:
//   - WAYS=2: one LRU bit naming the victim way
//   - WAYS=4: 3-bit tree pseudo-LRU
//   - WAYS=1: replacement state is kept but never consulted
//
// Ports
//   clk            clock; all state changes on the rising edge
//   rst            synchronous reset, active-high
//   pc             fetch PC used for the lookup
//   hit            a valid entry with a matching tag exists in pc's set
//   predict_taken  hit AND msb of the hitting way's counter
//   target_addr    stored target of the hitting way, 0 on miss
//   upd_valid      execute stage resolved a branch/jump this cycle
//   upd_pc         PC of the resolved branch
//   upd_target     resolved target address
//   upd_taken      resolved direction
//   stall          pipeline stall; suppresses the update
//   flush          invalidate every entry
// ---------------------------------------------------------------------------
module branch_target_buffer_sa #(
    parameter int         DATA_WIDTH = 32,
    parameter int         INDEX_BITS = 3,
    parameter int         WAYS       = 2,
    parameter logic [1:0] CNT_INIT   = 2'b10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  hit,
    output logic                  predict_taken,
    output logic [DATA_WIDTH-1:0] target_addr,
    input  logic                  upd_valid,
    input  logic [DATA_WIDTH-1:0] upd_pc,
    input  logic [DATA_WIDTH-1:0] upd_target,
    input  logic                  upd_taken,
    input  logic                  stall,
    input  logic                  flush
);

    localparam int SETS      = 1 << INDEX_BITS;
    localparam int TAG_BITS  = DATA_WIDTH - INDEX_BITS - 2;
    localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int REPL_BITS = (WAYS == 4) ? 3 : 1;

    // Any associativity other than 1, 2 or 4 is rejected at elaboration time.
    generate
        if (!(WAYS == 1 || WAYS == 2 || WAYS == 4)) begin : g_bad_ways
            btb_illegal_ways_parameter u_illegal_ways ();
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic                  valid_reg  [SETS][WAYS];
    logic [TAG_BITS-1:0]   tag_reg    [SETS][WAYS];
    logic [DATA_WIDTH-1:0] target_reg [SETS][WAYS];
    logic [1:0]            cnt_reg    [SETS][WAYS];
    logic [REPL_BITS-1:0]  repl_reg   [SETS];

    // ------------------------------------------------------------------
    // Address split. Bits [1:0] never take part in indexing or tagging.
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  unused_low_bits;

    assign lk_idx          = pc[INDEX_BITS+1:2];
    assign lk_tag          = pc[DATA_WIDTH-1:INDEX_BITS+2];
    assign up_idx          = upd_pc[INDEX_BITS+1:2];
    assign up_tag          = upd_pc[DATA_WIDTH-1:INDEX_BITS+2];
    assign unused_low_bits = ^{pc[1:0], upd_pc[1:0]};

    // ------------------------------------------------------------------
    // Per-way tag compare for both the lookup port and the update port
    // ------------------------------------------------------------------
    logic [WAYS-1:0] lk_match;
    logic [WAYS-1:0] up_match;
    logic [WAYS-1:0] up_invalid;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way_cmp
            assign lk_match[gi]   = valid_reg[lk_idx][gi] && (tag_reg[lk_idx][gi] == lk_tag);
            assign up_match[gi]   = valid_reg[up_idx][gi] && (tag_reg[up_idx][gi] == up_tag);
            assign up_invalid[gi] = !valid_reg[up_idx][gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Lookup. Allocation only happens on a miss, so at most one way can
    // match. The loop still resolves to the lowest matching way, which
    // keeps the mux well defined.
    // ------------------------------------------------------------------
    logic                lk_hit;
    logic [WAY_BITS-1:0] lk_way;

    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lk_match[w]) begin
                lk_hit = 1'b1;
                lk_way = WAY_BITS'(w);
            end
        end
    end

    assign hit           = lk_hit;
    assign predict_taken = lk_hit && cnt_reg[lk_idx][lk_way][1];
    assign target_addr   = lk_hit ? target_reg[lk_idx][lk_way] : '0;

    // ------------------------------------------------------------------
    // Update-side way selection
    // ------------------------------------------------------------------
    logic                 up_hit;
    logic [WAY_BITS-1:0]  up_hit_way;
    logic                 up_has_free;
    logic [WAY_BITS-1:0]  up_free_way;
    logic [WAY_BITS-1:0]  victim_way;
    logic [WAY_BITS-1:0]  access_way;
    logic [REPL_BITS-1:0] repl_cur;
    logic [REPL_BITS-1:0] repl_next;

    always_comb begin
        up_hit      = 1'b0;
        up_hit_way  = '0;
        up_has_free = 1'b0;
        up_free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (up_match[w]) begin
                up_hit     = 1'b1;
                up_hit_way = WAY_BITS'(w);
            end
            if (up_invalid[w]) begin
                up_has_free = 1'b1;
                up_free_way = WAY_BITS'(w);
            end
        end
    end

    // The accessed way is the hitting way on a hit. On an allocation it is
    // the lowest free way, falling back to the replacement victim.
    assign access_way = up_hit      ? up_hit_way  :
                        up_has_free ? up_free_way : victim_way;
    assign repl_cur   = repl_reg[up_idx];

    generate
        if (WAYS == 4) begin : g_plru4
            // Node bits:
            //   [0] root: 0 = victim in ways 0/1, 1 = victim in ways 2/3
            //   [1] left pair: names the victim within ways 0/1
            //   [2] right pair: names the victim within ways 2/3
            // An access points every node on its path away from the
            // accessed way.
            always_comb begin
                victim_way   = repl_cur[0] ? {1'b1, repl_cur[2]} : {1'b0, repl_cur[1]};
                repl_next    = repl_cur;
                repl_next[0] = ~access_way[1];
                if (!access_way[1]) begin
                    repl_next[1] = ~access_way[0];
                end else begin
                    repl_next[2] = ~access_way[0];
                end
            end
        end else if (WAYS == 2) begin : g_lru2
            assign victim_way = repl_cur;
            assign repl_next  = ~access_way;
        end else begin : g_direct
            logic unused_repl;
            assign victim_way  = '0;
            assign repl_next   = '0;
            assign unused_repl = ^repl_cur;
        end
    endgenerate

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // ------------------------------------------------------------------
    // State update. Reset beats flush, and flush beats a pending update.
    // Tag, target and counter are left untouched on flush. The valid
    // bits alone hide them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_reg[s][w] <= 1'b0;
                    cnt_reg[s][w]   <= 2'b01;
                end
                repl_reg[s] <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_reg[s][w] <= 1'b0;
                end
                repl_reg[s] <= '0;
            end
        end else if (upd_valid && !stall) begin
            if (up_hit) begin
                if (upd_taken) begin
                    target_reg[up_idx][access_way] <= upd_target;
                    cnt_reg[up_idx][access_way]    <= sat_inc(cnt_reg[up_idx][access_way]);
                end else begin
                    cnt_reg[up_idx][access_way] <= sat_dec(cnt_reg[up_idx][access_way]);
                end
                repl_reg[up_idx] <= repl_next;
            end else if (upd_taken) begin
                valid_reg[up_idx][access_way]  <= 1'b1;
                tag_reg[up_idx][access_way]    <= up_tag;
                target_reg[up_idx][access_way] <= upd_target;
                cnt_reg[up_idx][access_way]    <= CNT_INIT;
                repl_reg[up_idx]               <= repl_next;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer_sa.sv
// ---------------------------------------------------------------------------
// tb_branch_target_buffer_sa
//
// Two BTB instances (2-way and 4-way, otherwise default parameters) share
// the same stimulus.
//
// Each stimulus cycle computes the expected lookup response of both
// instances from a behavioural model of the buffer contents. It pushes
// those responses into per-instance queues and then advances the model by
// the update the clock edge will apply.
//
// A monitor on the falling edge pops the queues and compares them with
// the DUT outputs.
// ---------------------------------------------------------------------------
module tb_branch_target_buffer_sa;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;

    logic        hit2, pt2, hit4, pt4;
    logic [31:0] ta2, ta4;

    always #5 clk = ~clk;

    branch_target_buffer_sa #(.WAYS(2)) dut2 (
        .clk(clk), .rst(rst), .pc(pc), .hit(hit2), .predict_taken(pt2),
        .target_addr(ta2), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .stall(stall), .flush(flush)
    );

    branch_target_buffer_sa #(.WAYS(4)) dut4 (
        .clk(clk), .rst(rst), .pc(pc), .hit(hit4), .predict_taken(pt4),
        .target_addr(ta4), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .stall(stall), .flush(flush)
    );

    // ------------------------------------------------------------------
    // Reference model. Index k: 0 is the 2-way instance, 1 is the 4-way
    // instance.
    // ------------------------------------------------------------------
    bit          m_valid [2][8][4];
    int unsigned m_tag   [2][8][4];
    logic [31:0] m_tgt   [2][8][4];
    int          m_cnt   [2][8][4];
    int          m_repl  [2][8];

    function automatic int num_ways(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic void model_lookup(input int k, input logic [31:0] a,
                                         output logic h, output logic t, output logic [31:0] g);
        int set = int'((a >> 2) % 8);
        int unsigned tg = a >> 5;
        h = 1'b0; t = 1'b0; g = '0;
        for (int w = 0; w < num_ways(k); w++) begin
            if (m_valid[k][set][w] && m_tag[k][set][w] == tg) begin
                h = 1'b1;
                t = (m_cnt[k][set][w] >= 2);
                g = m_tgt[k][set][w];
            end
        end
    endfunction

    // Victim choice: a single "next victim" way for two ways, and a tree
    // of three decisions for four ways.
    function automatic int model_victim(input int k, input int set);
        int r = m_repl[k][set];
        if (num_ways(k) == 2) return r % 2;
        if (r % 2 == 0) return (r / 2) % 2;
        return 2 + (r / 4) % 2;
    endfunction

    function automatic void model_touch(input int k, input int set, input int w);
        int root, left, right;
        if (num_ways(k) == 2) begin
            m_repl[k][set] = 1 - w;
        end else begin
            root  = m_repl[k][set] % 2;
            left  = (m_repl[k][set] / 2) % 2;
            right = (m_repl[k][set] / 4) % 2;
            root  = (w < 2) ? 1 : 0;
            if (w < 2) left  = (w == 0) ? 1 : 0;
            else       right = (w == 2) ? 1 : 0;
            m_repl[k][set] = root + 2 * left + 4 * right;
        end
    endfunction

    function automatic void model_update(input int k, input bit uv, input logic [31:0] upc,
                                         input logic [31:0] ut, input bit utk,
                                         input bit st, input bit fl, input bit rs);
        int set = int'((upc >> 2) % 8);
        int unsigned tg = upc >> 5;
        int hw = -1;
        int fw = -1;
        if (rs || fl) begin
            for (int s = 0; s < 8; s++) begin
                for (int w = 0; w < 4; w++) begin
                    m_valid[k][s][w] = 1'b0;
                    if (rs) m_cnt[k][s][w] = 1;
                end
                m_repl[k][s] = 0;
            end
            return;
        end
        if (!uv || st) return;
        for (int w = 0; w < num_ways(k); w++) begin
            if (m_valid[k][set][w] && m_tag[k][set][w] == tg) hw = w;
            if (!m_valid[k][set][w] && fw < 0) fw = w;
        end
        if (hw >= 0) begin
            if (utk) begin
                m_tgt[k][set][hw] = ut;
                if (m_cnt[k][set][hw] < 3) m_cnt[k][set][hw]++;
            end else if (m_cnt[k][set][hw] > 0) begin
                m_cnt[k][set][hw]--;
            end
            model_touch(k, set, hw);
        end else if (utk) begin
            if (fw < 0) fw = model_victim(k, set);
            m_valid[k][set][fw] = 1'b1;
            m_tag[k][set][fw]   = tg;
            m_tgt[k][set][fw]   = ut;
            m_cnt[k][set][fw]   = 2;
            model_touch(k, set, fw);
        end
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          txn;
        logic [31:0] pc;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    exp_t q2[$];
    exp_t q4[$];
    int   checks = 0;
    int   errors = 0;
    int   txn_id = 0;
    bit   lk_valid = 1'b0;

    task automatic compare(input string nm, input exp_t e, input logic h,
                           input logic t, input logic [31:0] g);
        checks++;
        if ({h, t, g} !== {e.hit, e.taken, e.tgt}) begin
            errors++;
            $display("FAIL %s txn=%0d pc=%08h got hit=%b taken=%b target=%08h expected hit=%b taken=%b target=%08h",
                     nm, e.txn, e.pc, h, t, g, e.hit, e.taken, e.tgt);
        end else begin
            $display("ok   %s txn=%0d pc=%08h hit=%b taken=%b target=%08h",
                     nm, e.txn, e.pc, h, t, g);
        end
    endtask

    always @(negedge clk) begin
        if (lk_valid) begin
            if (q2.size() == 0 || q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow q2=%0d q4=%0d expected entries", q2.size(), q4.size());
            end else begin
                compare("w2", q2.pop_front(), hit2, pt2, ta2);
                compare("w4", q4.pop_front(), hit4, pt4, ta4);
            end
        end
    end

    // One stimulus cycle: drive inputs, capture the pre-edge expectation,
    // then advance the model by the edge's update.
    task automatic step(input logic [31:0] a, input bit uv, input logic [31:0] upc,
                        input logic [31:0] ut, input bit utk, input bit st,
                        input bit fl, input bit rs, input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        pc = a; upd_valid = uv; upd_pc = upc; upd_target = ut; upd_taken = utk;
        stall = st; flush = fl; rst = rs;
        txn_id++;
        if (chk) begin
            e.txn = txn_id;
            e.pc  = a;
            model_lookup(0, a, e.hit, e.taken, e.tgt);
            q2.push_back(e);
            model_lookup(1, a, e.hit, e.taken, e.tgt);
            q4.push_back(e);
        end
        lk_valid = chk;
        for (int k = 0; k < 2; k++) model_update(k, uv, upc, ut, utk, st, fl, rs);
    endtask

    task automatic look(input logic [31:0] a);
        step(a, 0, 32'h0, 32'h0, 0, 0, 0, 0, 1);
    endtask

    task automatic upd(input logic [31:0] a, input logic [31:0] ut, input bit utk);
        step(a, 1, a, ut, utk, 0, 0, 0, 1);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] v = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
        return v;
    endfunction

    initial begin
        logic [31:0] a, b;
        bit uv, tk, st, fl, rs;

        // Reset. Outputs are unknown during the first cycle, so it is not checked.
        step(32'h40, 0, 0, 0, 0, 0, 0, 1, 0);
        look(32'h40);

        // Allocate and hit
        upd(32'h40, 32'h100, 1);
        look(32'h40);
        look(32'h44);

        // Associativity and replacement in set 0
        upd(32'h80, 32'h200, 1);
        look(32'h40);
        look(32'h80);
        upd(32'h40, 32'h104, 1);
        upd(32'hC0, 32'h300, 1);
        look(32'h80);
        look(32'h40);
        look(32'hC0);

        // Counter saturation on 0x40
        for (int i = 0; i < 4; i++) begin
            upd(32'h40, 32'h0, 0);
            look(32'h40);
        end
        for (int i = 0; i < 4; i++) begin
            upd(32'h40, 32'h500 + 32'(i * 4), 1);
            look(32'h40);
        end
        upd(32'h1C0, 32'h700, 0);
        look(32'h1C0);

        // Stall, and same-cycle update/lookup without bypass
        step(32'h60, 1, 32'h60, 32'h600, 1, 1, 0, 0, 1);
        look(32'h60);
        step(32'h60, 1, 32'h60, 32'h600, 1, 0, 0, 0, 1);
        look(32'h60);

        // Flush and reset priority over an update
        upd(32'hA0, 32'hA00, 1);
        look(32'hA0);
        step(32'hA0, 1, 32'hA0, 32'hA10, 1, 0, 1, 0, 1);
        look(32'hA0);
        look(32'h60);
        upd(32'hA0, 32'hA00, 1);
        step(32'hA0, 1, 32'hA0, 32'hA10, 1, 0, 0, 1, 1);
        look(32'hA0);
        upd(32'h40, 32'h140, 1);
        look(32'h40);

        // Five tags into set 3; the 4-way instance must evict 0x0C
        step(32'h0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) upd(32'h0C + 32'(i * 32), 32'h1000 + 32'(i * 16), 1);
        for (int i = 0; i < 5; i++) look(32'h0C + 32'(i * 32));

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            a  = rand_pc();
            b  = ($urandom_range(0, 1) == 1) ? a : rand_pc();
            uv = ($urandom_range(0, 2) != 0);
            tk = ($urandom_range(0, 9) < 6);
            st = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 59) == 0);
            step(a, uv, b, $urandom(), tk, st, fl, rs, 1);
        end

        // Drain the scoreboard
        @(posedge clk);
        #1;
        lk_valid = 1'b0;
        upd_valid = 1'b0;
        @(posedge clk);
        checks++;
        if (q2.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got q2=%0d q4=%0d expected 0", q2.size(), q4.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
